fp_result_stage: RTL and testbench
==================================

# fp_result_stage

Registered output stage directly downstream of the combinational floating-point add/sub unit. It captures each 32-bit result together with its overflow, underflow and exception flags, and substitutes IEEE-754 special values for flagged results. Fixed-up results are queued in a small FIFO with a valid/ready handshake toward the consumer, and optional sticky status flags are kept. This stage gives the add/sub datapath a clean, back-pressurable, registered boundary.

## Interface
- `DEPTH`, default 2: FIFO entries; power of two, 2..8.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: the add/sub result on `in_*` is valid.
- `in_ready`  out  1: stage can accept; `count < DEPTH`.
- `in_result`  in  32: add/sub result `{sign, exp[7:0], mant[22:0]}`.
- `in_overflow`  in  1: add/sub overflow flag.
- `in_underflow`  in  1: add/sub underflow flag.
- `in_exception`  in  1: add/sub exception (an operand had an all-ones exponent).
- `out_valid`  out  1: head entry is valid; `count != 0`.
- `out_ready`  in  1: consumer takes head entry.
- `out_data`  out  32: fixed-up result at the head.
- `out_flags`  out  3: head entry flags `{exc, ovf, unf}`.
- `sticky_flags`  out  3: OR of all accepted flags since reset or clear, ordered `{exc, ovf, unf}`.
- `sticky_clr`  in  1: synchronous clear of `sticky_flags`.
- `count`  out  clog2(DEPTH)+1: current occupancy.

## Operation
- Push when `in_valid & in_ready`. Pop when `out_valid & out_ready`.
- Fix-up is combinational before the FIFO write. Priority is exc > ovf > unf; `s` is `in_result[31]`:
  - exception: write `32'h7FC0_0000`.
  - overflow: write `{s, 8'hFF, 23'h0}`.
  - underflow: write `{s, 31'h0}`.
  - otherwise: write `in_result` unchanged.
- Stored flags are the raw three input flags, not priority-reduced.
- `in_ready` depends only on `count`, never on `out_ready`. A full FIFO has no same-cycle pass-through.
- Push and pop in the same cycle: `count` is unchanged, and the head advances while the tail writes.
- Empty FIFO: no bypass path. The written entry appears at `out_data` one cycle after the push edge.
- Read and write pointers wrap modulo `DEPTH`. Full/empty state comes from `count`.
- While `out_valid` is high and not popped, `out_data` and `out_flags` stay stable.
- `in_*` values are ignored when no push occurs.

## Timing
- Latency from push edge to `out_valid` is 1 cycle.
- Sustained throughput is 1 result per cycle when `out_ready` stays high.
- Reset values:
  - `count` = 0, `out_valid` = 0, `in_ready` = 1.
  - `out_data` = 0, `out_flags` = 0, `sticky_flags` = 0.
  - Pointers = 0.
- Reset asserted mid-operation discards all entries immediately (asynchronous).
- `out_data` and `out_flags` are driven from storage, not from the `in_*` inputs.
- When `count == 0`, `out_data` and `out_flags` read 0.

## Configuration
- Macro: `FP_RESULT_STICKY_EN`.
- Defined:
  - `sticky_flags` updates on each push as `sticky | new_flags`.
  - `sticky_clr` takes effect at the edge.
  - `sticky_clr` together with a push in the same cycle leaves `sticky_flags = new_flags` only.
- Not defined:
  - `sticky_flags` is tied to `3'b000`.
  - `sticky_clr` is ignored.
  - No sticky register is inferred.

## Structure
- Shared package `fpu_pkg` holds:
  - `FP_QNAN = 32'h7FC0_0000`
  - flag bit indices `FLG_UNF = 0`, `FLG_OVF = 1`, `FLG_EXC = 2`
  - typedef `fp_flags_t` (3-bit).
- Sub-module `fp_result_fifo`:
  - generic DEPTH × 35-bit synchronous FIFO with `count`.
  - asynchronous active-high reset.
- Top level contains the fix-up logic, the sticky register and the port wiring.

## Test plan
- Normal result: push `0x4040_0000` with flags 0 → next cycle `out_valid = 1`, `out_data = 0x4040_0000`, `out_flags = 0`.
- Special-value substitution:
  - push `0xC1234567` with ovf=1 → `out_data = 0xFF80_0000`.
  - push `0x8012_3456` with unf=1 → `0x8000_0000`.
  - push any value with exc=1, ovf=1 → `0x7FC0_0000`, `out_flags = 3'b110`.
- Back-pressure (`DEPTH = 2`): `out_ready = 0`, push 3 results → `in_ready = 0` after 2, third not accepted. Then `out_ready = 1` → entries drain in order, `count` goes 2, 1, 0.
- Simultaneous push/pop at `count = 1` → `count` stays 1, order preserved. Continuous streaming of 16 values → one output per cycle, no loss.
- Sticky (macro defined):
  - pushes with unf, then ovf → `sticky = 3'b011`.
  - `sticky_clr` together with an exc push → `sticky = 3'b100`.
  - with macro undefined → `sticky` is always 0.
- Reset with `count = 2` asserted asynchronously mid-cycle → immediately `out_valid = 0`, `count = 0`, `in_ready = 1`, `sticky = 0`.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point add/sub result path:
// special values, flag bit positions, the FIFO entry payload and the special-value fix-up.
package fpu_pkg;

    localparam int unsigned FP_W    = 32;
    localparam int unsigned FLG_W   = 3;
    localparam int unsigned ENTRY_W = FP_W + FLG_W;

    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

    localparam int unsigned FLG_UNF = 0;
    localparam int unsigned FLG_OVF = 1;
    localparam int unsigned FLG_EXC = 2;

    typedef logic [FLG_W-1:0] fp_flags_t;

    // One queued result: raw flags {exc, ovf, unf} above the fixed-up value
    typedef struct packed {
        fp_flags_t       flags;
        logic [FP_W-1:0] data;
    } fp_entry_t;

    // Replace flagged results with IEEE-754 specials; exc beats ovf beats unf
    function automatic logic [FP_W-1:0] fp_fixup(input logic [FP_W-1:0] res,
                                                 input fp_flags_t       flg);
        logic [FP_W-1:0] r;
        if (flg[FLG_EXC])      r = FP_QNAN;
        else if (flg[FLG_OVF]) r = {res[31], 8'hFF, 23'h0};
        else if (flg[FLG_UNF]) r = {res[31], 31'h0};
        else                   r = res;
        return r;
    endfunction

endpackage

// File: rtl/fp_result_stage_if.sv
// Producer/consumer bundle of fp_result_stage (handshakes, payloads, sticky status, occupancy).
interface fp_result_stage_if #(
    parameter int unsigned DEPTH = 2
);
    import fpu_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [FP_W-1:0]   in_result;
    logic              in_overflow;
    logic              in_underflow;
    logic              in_exception;
    logic              out_valid;
    logic              out_ready;
    logic [FP_W-1:0]   out_data;
    fp_flags_t         out_flags;
    fp_flags_t         sticky_flags;
    logic              sticky_clr;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_result, in_overflow, in_underflow, in_exception,
               out_ready, sticky_clr,
        input  in_ready, out_valid, out_data, out_flags, sticky_flags, count
    );

    modport slave (
        input  in_valid, in_result, in_overflow, in_underflow, in_exception,
               out_ready, sticky_clr,
        output in_ready, out_valid, out_data, out_flags, sticky_flags, count
    );

endinterface

// File: rtl/fp_result_fifo.sv
// Generic DEPTH x 35-bit synchronous FIFO with occupancy count; async active-high reset.
// Head reads as zero when empty; full/empty come from the count, pointers wrap naturally.
module fp_result_fifo
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  fp_entry_t                  wr_data_i,
    output fp_entry_t                  rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    fp_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               wr_en, rd_en;

    // Qualify requests against occupancy and compute next pointers/count
    always_comb begin
        wr_en    = push_i && (count_q < CNT_W'(DEPTH));
        rd_en    = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while unoccupied
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o   = count_q;

endmodule

// File: rtl/fp_result_stage.sv
// Registered output stage for the FP add/sub unit: special-value fix-up, result FIFO,
// valid/ready handshake and optional sticky flags (enabled by macro FP_RESULT_STICKY_EN).
module fp_result_stage
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_result_stage_if.slave     bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              push, pop;
    fp_flags_t         in_flags;
    fp_entry_t         wr_entry, rd_entry;
    logic [CNT_W-1:0]  count;

    // Gather raw flags and build the fixed-up entry to enqueue
    always_comb begin
        in_flags          = '0;
        in_flags[FLG_EXC] = bus.in_exception;
        in_flags[FLG_OVF] = bus.in_overflow;
        in_flags[FLG_UNF] = bus.in_underflow;
        wr_entry.flags    = in_flags;
        wr_entry.data     = fp_fixup(bus.in_result, in_flags);
    end

    assign bus.in_ready  = (count < CNT_W'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    fp_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (wr_entry),
        .rd_data_o (rd_entry),
        .count_o   (count)
    );

    assign bus.out_data  = rd_entry.data;
    assign bus.out_flags = rd_entry.flags;
    assign bus.count     = count;

`ifdef FP_RESULT_STICKY_EN
    fp_flags_t sticky_q, sticky_d;

    // Clear first so a clear alongside a push keeps only the new flags
    always_comb begin
        sticky_d = sticky_q;
        if (bus.sticky_clr) sticky_d = '0;
        if (push)           sticky_d = sticky_d | in_flags;
    end

    // Sticky status register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sticky_q <= '0;
        else     sticky_q <= sticky_d;
    end

    assign bus.sticky_flags = sticky_q;
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = bus.sticky_clr;
    assign bus.sticky_flags  = '0;
`endif

endmodule

// File: tb/tb_fp_result_stage.sv
// Directed self-checking bench for fp_result_stage (DEPTH = 2); sticky expectations
// follow FP_RESULT_STICKY_EN.
module tb_fp_result_stage;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    fp_result_stage_if #(.DEPTH(2)) bus ();

    fp_result_stage #(.DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [2:0] stk(input logic [2:0] v);
`ifdef FP_RESULT_STICKY_EN
        return v;
`else
        return 3'b000;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] res, input logic exc, input logic ovf, input logic unf);
        bus.in_valid     = 1'b1;
        bus.in_result    = res;
        bus.in_exception = exc;
        bus.in_overflow  = ovf;
        bus.in_underflow = unf;
        step();
        bus.in_valid     = 1'b0;
        bus.in_exception = 1'b0;
        bus.in_overflow  = 1'b0;
        bus.in_underflow = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] data, input logic [2:0] flg);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_data"},  bus.out_data, data);
        check({tag, "_flags"}, 32'(bus.out_flags), 32'(flg));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_result = '0; bus.in_exception = 1'b0;
        bus.in_overflow = 1'b0; bus.in_underflow = 1'b0;
        bus.out_ready = 1'b0; bus.sticky_clr = 1'b0;

        // Reset state
        #3;
        check("rst_count",  32'(bus.count), 32'd0);
        check("rst_ovalid", 32'(bus.out_valid), 32'd0);
        check("rst_iready", 32'(bus.in_ready), 32'd1);
        check("rst_odata",  bus.out_data, 32'h0);
        check("rst_oflags", 32'(bus.out_flags), 32'd0);
        check("rst_sticky", 32'(bus.sticky_flags), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Normal result, one-cycle latency
        push_one(32'h4040_0000, 1'b0, 1'b0, 1'b0);
        check("norm_count", 32'(bus.count), 32'd1);
        pop_check("norm", 32'h4040_0000, 3'b000);
        check("norm_empty_count", 32'(bus.count), 32'd0);
        check("norm_empty_data", bus.out_data, 32'h0);

        // Special-value substitution with sticky accumulation
        push_one(32'h8012_3456, 1'b0, 1'b0, 1'b1);
        check("unf_sticky", 32'(bus.sticky_flags), 32'(stk(3'b001)));
        pop_check("unf", 32'h8000_0000, 3'b001);
        push_one(32'hC123_4567, 1'b0, 1'b1, 1'b0);
        check("ovf_sticky", 32'(bus.sticky_flags), 32'(stk(3'b011)));
        pop_check("ovf", 32'hFF80_0000, 3'b010);
        push_one(32'h1234_5678, 1'b1, 1'b1, 1'b0);
        check("exc_sticky", 32'(bus.sticky_flags), 32'(stk(3'b111)));
        pop_check("exc", 32'h7FC0_0000, 3'b110);
        bus.sticky_clr = 1'b1;
        push_one(32'h3F80_0000, 1'b1, 1'b0, 1'b0);
        bus.sticky_clr = 1'b0;
        check("clrpush_sticky", 32'(bus.sticky_flags), 32'(stk(3'b100)));
        pop_check("clrpush", 32'h7FC0_0000, 3'b100);
        bus.sticky_clr = 1'b1;
        step();
        bus.sticky_clr = 1'b0;
        check("clr_sticky", 32'(bus.sticky_flags), 32'd0);

        // Back-pressure: third push refused, inputs ignored, drain in order
        push_one(32'h3F80_0000, 1'b0, 1'b0, 1'b0);
        push_one(32'h4000_0000, 1'b0, 1'b0, 1'b0);
        check("bp_count_full", 32'(bus.count), 32'd2);
        check("bp_iready", 32'(bus.in_ready), 32'd0);
        push_one(32'h4080_0000, 1'b1, 1'b0, 1'b0);
        check("bp_count_hold", 32'(bus.count), 32'd2);
        check("bp_sticky_hold", 32'(bus.sticky_flags), 32'd0);
        check("bp_head_stable", bus.out_data, 32'h3F80_0000);
        pop_check("bp_a", 32'h3F80_0000, 3'b000);
        check("bp_count1", 32'(bus.count), 32'd1);
        pop_check("bp_b", 32'h4000_0000, 3'b000);
        check("bp_count0", 32'(bus.count), 32'd0);

        // Simultaneous push and pop at count 1
        push_one(32'h1111_1111, 1'b0, 1'b0, 1'b0);
        bus.in_valid  = 1'b1;
        bus.in_result = 32'h2222_2222;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("pp_count", 32'(bus.count), 32'd1);
        pop_check("pp", 32'h2222_2222, 3'b000);

        // Continuous streaming at full rate
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_result = 32'h0000_1000 + 32'(i);
            step();
            check("stream_data", bus.out_data, 32'h0000_1000 + 32'(i));
            check("stream_count", 32'(bus.count), 32'd1);
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        check("stream_drained", 32'(bus.count), 32'd0);

        // Asynchronous reset mid-cycle with a full FIFO
        push_one(32'h3F80_0000, 1'b0, 1'b0, 1'b1);
        push_one(32'h4000_0000, 1'b0, 1'b0, 1'b0);
        check("ar_count_pre", 32'(bus.count), 32'd2);
        check("ar_sticky_pre", 32'(bus.sticky_flags), 32'(stk(3'b001)));
        #2;
        rst = 1'b1;
        #1;
        check("ar_ovalid", 32'(bus.out_valid), 32'd0);
        check("ar_count", 32'(bus.count), 32'd0);
        check("ar_iready", 32'(bus.in_ready), 32'd1);
        check("ar_sticky", 32'(bus.sticky_flags), 32'd0);
        check("ar_odata", bus.out_data, 32'h0);
        step();
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
